// File: rtl/ov7670_stream_gen_if.sv
// ov7670_stream_gen_if: frame-buffer read port plus OV7670-style DVP output stream.
interface ov7670_stream_gen_if;
    logic        run;
    logic [11:0] pix_data;
    logic        rd_en;
    logic [18:0] rd_addr;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        busy;
    logic        frame_done;
    modport master (
        input  run, pix_data,
        output rd_en, rd_addr, vsync, href, d, busy, frame_done
    );
    modport slave (
        output run, pix_data,
        input  rd_en, rd_addr, vsync, href, d, busy, frame_done
    );
endinterface

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: replays an RGB444 frame buffer as an OV7670 RGB444 DVP byte stream.
module ov7670_stream_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 144,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input logic clk,
    input logic rst,
    ov7670_stream_gen_if.master bus
);
    localparam int L  = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(L);
    localparam int VW = 16;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
    state_t st, nst;
    logic [HW-1:0] h, nh;
    logic [VW-1:0] v, nv, n_lines;
    logic [7:0] gb;
    logic last_h, end_st, href_n, first_byte, fire;
    // Outputs are registered from the next-cycle state so they line up with the state itself.
    always_comb begin
        n_lines = st == VSYNC ? VW'(VS_LINES) : st == VBACK ? VW'(VBP_LINES) :
                  st == ACTIVE ? VW'(V_ACTIVE) : VW'(VFP_LINES);
        last_h = h == HW'(L - 1);
        end_st = last_h && v == n_lines - 1'b1;
        nh = st == IDLE || last_h ? '0 : h + 1'b1;
        nv = st == IDLE || end_st ? '0 : last_h ? v + 1'b1 : v;
        nst = st == IDLE ? (bus.run ? VSYNC : IDLE) : !end_st ? st :
              st == VSYNC ? VBACK : st == VBACK ? ACTIVE : st == ACTIVE ? VFRONT :
              (bus.run ? VSYNC : IDLE);
        href_n = nst == ACTIVE && nh < HW'(2 * H_ACTIVE);
        first_byte = href_n && !nh[0];
        // Read two cycles ahead of each first byte; a line's first pixel is fetched in the previous line's blanking.
        fire = (nst == ACTIVE && !nh[0] && nh < HW'(2 * H_ACTIVE - 2)) ||
               (nh == HW'(L - 2) && ((nst == VBACK && nv == VW'(VBP_LINES - 1)) ||
                                     (nst == ACTIVE && nv != VW'(V_ACTIVE - 1))));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= IDLE;
            h              <= '0;
            v              <= '0;
            gb             <= '0;
            bus.vsync      <= 1'b0;
            bus.href       <= 1'b0;
            bus.d          <= 8'h00;
            bus.rd_en      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            st             <= nst;
            h              <= nh;
            v              <= nv;
            if (first_byte) gb <= bus.pix_data[7:0];
            bus.vsync      <= nst == VSYNC;
            bus.href       <= href_n;
            bus.d          <= !href_n ? 8'h00 : nh[0] ? gb : {4'h0, bus.pix_data[11:8]};
            bus.rd_en      <= fire;
            bus.rd_addr    <= nst == VSYNC ? '0 : bus.rd_addr + 19'(bus.rd_en);
            bus.busy       <= nst != IDLE;
            bus.frame_done <= nst == VFRONT && nh == HW'(L - 1) && nv == VW'(VFP_LINES - 1);
        end
    end
endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144: HREF-low clk cycles per line, legal range >=2.
REQ-004 SHALL have parameter VS_LINES, default 3; VBP_LINES, default 17; VFP_LINES, default 10: vsync, back-porch and front-porch line counts, each >=1.
REQ-005 SHALL have port clk, input, 1: single clock, one byte-time (PCLK) per cycle.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port run, input, 1: frame generation enable, sampled only at frame boundaries.
REQ-008 SHALL have port pix_data, input, 12: RGB444 {R,G,B} from a synchronous-read frame buffer, valid exactly one cycle after rd_en.
REQ-009 SHALL have port rd_en, output, 1: frame-buffer read strobe.
REQ-010 SHALL have port rd_addr, output, 19: pixel address, row*H_ACTIVE+col.
REQ-011 SHALL have port vsync, output, 1; href, output, 1; d, output, 8: OV7670-style DVP stream, same format ov7670_capture_verilog consumes.
REQ-012 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-013 SHALL have port frame_done, output, 1: single-cycle end-of-frame pulse.

Function
REQ-014 SHALL implement states IDLE, VSYNC, VBACK, ACTIVE, VFRONT; line length L = 2*H_ACTIVE+H_BLANK cycles in every non-IDLE state.
REQ-015 SHALL move IDLE->VSYNC on the cycle after run=1 is sampled in IDLE; otherwise remain in IDLE.
REQ-016 SHALL move VSYNC->VBACK after VS_LINES*L cycles, VBACK->ACTIVE after VBP_LINES*L cycles, ACTIVE->VFRONT after V_ACTIVE*L cycles.
REQ-017 SHALL, at the end of VFRONT (VFP_LINES*L cycles), go to VSYNC if run=1 that cycle, else to IDLE, with no gap cycle in either case.
REQ-018 SHALL drive vsync=1 for exactly every cycle of the VSYNC state, 0 otherwise.
REQ-019 SHALL, in each ACTIVE line, drive href=1 for the first 2*H_ACTIVE cycles and 0 for the last H_BLANK cycles; href=0 in all other states.
REQ-020 SHALL output per pixel two consecutive href bytes: first d={4'h0,R}, second d={G,B}.
REQ-021 SHALL drive d=8'h00 whenever href=0.
REQ-022 SHALL pulse rd_en for one cycle exactly 2 cycles before the cycle in which that pixel's first byte appears on d, with rd_addr valid in the same cycle.
REQ-023 SHALL register pix_data on the cycle after rd_en and hold it for both bytes of that pixel.
REQ-024 SHALL produce rd_addr 0..H_ACTIVE*V_ACTIVE-1 in ascending order per frame, restarting at 0 each frame; rd_en count per frame = H_ACTIVE*V_ACTIVE exactly.
REQ-025 SHALL hold busy=1 in VSYNC, VBACK, ACTIVE, VFRONT; busy=0 in IDLE.
REQ-026 SHALL pulse frame_done on the last cycle of VFRONT only.
REQ-027 SHALL ignore run changes mid-frame; a started frame always completes.
REQ-028 SHALL register all outputs; no combinational path from run or pix_data to any output.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, force state IDLE, all counters 0, and vsync, href, d, rd_en, rd_addr, busy, frame_done to 0 on the following cycle.
REQ-030 SHALL give rst priority over run and over any in-progress frame; after reset release, start only per REQ-015.

Verification (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=4, VS/VBP/VFP=1 -> L=12, frame=60 cycles)
REQ-031 SHALL verify: rst then run=0 for 100 cycles -> vsync, href, rd_en, busy all remain 0.
REQ-032 SHALL verify: run=1 pulse in IDLE -> vsync high 12 cycles, 12 cycles quiet, two 8-cycle href bursts 4 cycles apart, frame_done once at cycle 60 of the frame, then IDLE.
REQ-033 SHALL verify: buffer model pix_data=12'h{addr}+12'hA50 -> d pairs 0A,50 / 0A,51 / ...; rd_addr 0..7, each rd_en exactly 2 cycles ahead of the first byte.
REQ-034 SHALL verify: run held 1 -> vsync rises on the cycle after frame_done with zero gap; rd_addr restarts at 0.
REQ-035 SHALL verify: run dropped during ACTIVE -> frame completes, 8 rd_en total, then IDLE.
REQ-036 SHALL verify: rst asserted mid-href -> next cycle href=0, d=00, busy=0; rerun produces rd_addr from 0.
